// File: rtl/core_pkg.sv
// Shared core encodings: execute-stage forwarding selects and the x0 index,
// plus the decode-to-execute shadow record used by the hazard unit.
package core_pkg;
    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
    } e_shadow_t;
endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one execute-stage source register.
// The memory-stage result is younger, so it beats writeback; x0 never forwards.
module hazard_fwd_sel
    import core_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_m,
    input  logic       i_regwrite_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_regwrite_w,
    output logic [1:0] o_fwd
);
    logic w_hit_m;
    logic w_hit_w;

    assign w_hit_m = i_regwrite_m && (i_rd_m != REG_ZERO) && (i_rd_m == i_rs);
    assign w_hit_w = i_regwrite_w && (i_rd_w != REG_ZERO) && (i_rd_w == i_rs);

    always_comb begin
        o_fwd = FWD_RF;
        if (w_hit_m)
            o_fwd = FWD_MEM;
        else if (w_hit_w)
            o_fwd = FWD_WB;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: E/M/W shadow registers, forwarding
// selects, load-use stall, branch flush and saturating event counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic             LoadD,
    input  logic             PCSrcE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    e_shadow_t        r_e;
    logic [4:0]       r_rd_m;
    logic             r_regwrite_m;
    logic [4:0]       r_rd_w;
    logic             r_regwrite_w;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_lwstall;
    e_shadow_t        w_d;

    assign w_d = '{rs1: Rs1D, rs2: Rs2D, rd: RdD, regwrite: RegWriteD, load: LoadD};

    // A taken branch squashes the dependent instruction anyway, so it suppresses the stall.
    assign w_lwstall = r_e.load && r_e.regwrite && (r_e.rd != REG_ZERO) &&
                       ((r_e.rd == Rs1D) || (r_e.rd == Rs2D)) && !PCSrcE;

    assign StallF    = w_lwstall;
    assign StallD    = w_lwstall;
    assign FlushD    = PCSrcE;
    assign FlushE    = w_lwstall || PCSrcE;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    hazard_fwd_sel u_fwd_a (
        .i_rs         (r_e.rs1),
        .i_rd_m       (r_rd_m),
        .i_regwrite_m (r_regwrite_m),
        .i_rd_w       (r_rd_w),
        .i_regwrite_w (r_regwrite_w),
        .o_fwd        (ForwardAE)
    );

    hazard_fwd_sel u_fwd_b (
        .i_rs         (r_e.rs2),
        .i_rd_m       (r_rd_m),
        .i_regwrite_m (r_regwrite_m),
        .i_rd_w       (r_rd_w),
        .i_regwrite_w (r_regwrite_w),
        .o_fwd        (ForwardBE)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_e          <= '0;
            r_rd_m       <= REG_ZERO;
            r_regwrite_m <= 1'b0;
            r_rd_w       <= REG_ZERO;
            r_regwrite_w <= 1'b0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_e          <= FlushE ? '0 : w_d;
            r_rd_m       <= r_e.rd;
            r_regwrite_m <= r_e.regwrite;
            r_rd_w       <= r_rd_m;
            r_regwrite_w <= r_regwrite_m;
            if (w_lwstall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (PCSrcE && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl (CNT_W = 4 so saturation is reachable).
module tb_hazard_ctrl;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       Rs1D, Rs2D, RdD;
    logic             RegWriteD, LoadD, PCSrcE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, FlushD, FlushE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .LoadD(LoadD), .PCSrcE(PCSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       rw, ld, br;
        logic [1:0] fa, fb;
        logic       stall, fd, fe;
        int         sc, fc;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic [4:0] rs1, rs2, rd, input logic rw, ld, br,
                                input logic [1:0] fa, fb, input logic stall, fd, fe,
                                input int sc, fc);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rw = rw; v.ld = ld; v.br = br;
        v.fa = fa; v.fb = fb; v.stall = stall; v.fd = fd; v.fe = fe; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, rs2, rd, input logic rw, ld, br);
        Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; LoadD = ld; PCSrcE = br;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, ".ForwardAE"}, int'(ForwardAE), int'(v.fa));
        chk({tag, ".ForwardBE"}, int'(ForwardBE), int'(v.fb));
        chk({tag, ".StallF"},    int'(StallF),    int'(v.stall));
        chk({tag, ".StallD"},    int'(StallD),    int'(v.stall));
        chk({tag, ".FlushD"},    int'(FlushD),    int'(v.fd));
        chk({tag, ".FlushE"},    int'(FlushE),    int'(v.fe));
        chk({tag, ".stall_cnt"}, int'(stall_cnt), v.sc);
        chk({tag, ".flush_cnt"}, int'(flush_cnt), v.fc);
    endtask

    initial begin
        // Pipeline contents in E/M/W noted per vector (state seen when checked).
        vecs[0]  = mk(1, 2, 5, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // add x5 in D
        vecs[1]  = mk(5, 5, 6, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // sub x6,x5,x5; E=add5
        vecs[2]  = mk(0, 0, 0, 0, 0, 0,  2'b10, 2'b10, 0, 0, 0, 0, 0); // E=sub, M=add5
        vecs[3]  = mk(0, 0, 5, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // add x5
        vecs[4]  = mk(0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // nop
        vecs[5]  = mk(5, 3, 8, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // use x5
        vecs[6]  = mk(0, 0, 5, 1, 0, 0,  2'b01, 2'b00, 0, 0, 0, 0, 0); // E=use, W=add5
        vecs[7]  = mk(0, 0, 5, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // second add x5
        vecs[8]  = mk(5, 5, 9, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // use x5
        vecs[9]  = mk(0, 0, 0, 0, 0, 0,  2'b10, 2'b10, 0, 0, 0, 0, 0); // M beats W
        vecs[10] = mk(0, 0, 0, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // write to x0
        vecs[11] = mk(0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // reads x0
        vecs[12] = mk(0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // RdM=0 RegWriteM=1
        vecs[13] = mk(0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // RdW=0 RegWriteW=1
        vecs[14] = mk(1, 0, 7, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // lw x7
        vecs[15] = mk(3, 7, 10, 1, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0); // load-use stall
        vecs[16] = mk(3, 7, 10, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0); // held D, E=bubble
        vecs[17] = mk(0, 0, 0, 0, 0, 0,  2'b00, 2'b01, 0, 0, 0, 1, 0); // E=use, W=lw7
        vecs[18] = mk(1, 0, 7, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 1, 0); // lw x7
        vecs[19] = mk(7, 0, 11, 1, 0, 1, 2'b00, 2'b00, 0, 1, 1, 1, 0); // branch wins
        vecs[20] = mk(11, 11, 12, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1); // read flushed x11
        vecs[21] = mk(11, 7, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1);
        vecs[22] = mk(0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 1);

        // Reset with random decode inputs, no branch.
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_outs("reset", mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw, vecs[i].ld, vecs[i].br);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk); #1;
        end

        // Flush counter saturates at 15 (started at 1).
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            @(negedge clk);
            chk($sformatf("sat.FlushE%0d", i), int'(FlushE), 1);
            if (i == 10) chk("sat.flush_cnt_mid", int'(flush_cnt), 11);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat.flush_cnt", int'(flush_cnt), 15);
        chk("sat.stall_cnt", int'(stall_cnt), 1);

        // Reset asserted while a load-use stall is active.
        @(posedge clk); #1;
        drive(1, 0, 7, 1, 1, 0);
        @(posedge clk); #1;
        drive(7, 0, 3, 1, 0, 0);
        @(negedge clk);
        chk("midstall.StallF", int'(StallF), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midstall.StallF_after", int'(StallF), 0);
        chk("midstall.FlushE_after", int'(FlushE), 0);
        chk("midstall.stall_cnt", int'(stall_cnt), 0);
        chk("midstall.flush_cnt", int'(flush_cnt), 0);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller for the 5-stage core; it drives the execute-stage operand forwarding muxes.
- Tracks source and destination register indices and write enables of in-flight instructions through its own E/M/W shadow registers, loaded from decode-stage fields.
- From these it generates the 2-bit forwarding selects, the load-use stall and the branch flush.
- Also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- Rs1D  input  5  rs1 index of the instruction in decode.
- Rs2D  input  5  rs2 index of the instruction in decode.
- RdD  input  5  rd index of the instruction in decode.
- RegWriteD  input  1  decode instruction writes rd.
- LoadD  input  1  decode instruction is a load (ResultSrcD[0]).
- PCSrcE  input  1  branch or jump taken, resolved in execute.
- ForwardAE  output  2  SrcAE select: 00 RD1E, 01 ResultW, 10 ALUResultM; 11 is never driven.
- ForwardBE  output  2  same encoding for SrcBE.
- StallF  output  1  hold the PC register.
- StallD  output  1  hold the IF/ID register.
- FlushD  output  1  clear the IF/ID register.
- FlushE  output  1  clear the ID/EX register (insert bubble).
- stall_cnt  output  CNT_W  count of load-use stall cycles, saturating.
- flush_cnt  output  CNT_W  count of PCSrcE flush cycles, saturating.

## Operation
Shadow state, one set per stage:
- E stage: Rs1E, Rs2E, RdE, RegWriteE, LoadE.
- M stage: RdM, RegWriteM.
- W stage: RdW, RegWriteW.

Update every cycle:
- E loads the D fields, or all zeros when FlushE = 1.
- M loads from E.
- W loads from M.

Forwarding, evaluated combinationally from the shadow registers. ForwardAE uses Rs1E; ForwardBE uses Rs2E identically:
- 10 if RegWriteM and RdM ≠ 0 and RdM == Rs1E.
- Otherwise 01 if RegWriteW and RdW ≠ 0 and RdW == Rs1E.
- Otherwise 00.
- M has priority over W. Register x0 is never forwarded.

Load-use stall:
- lwStall = LoadE & RegWriteE & (RdE ≠ 0) & (RdE == Rs1D | RdE == Rs2D) & ~PCSrcE.

Control outputs:
- StallF = StallD = lwStall.
- FlushD = PCSrcE.
- FlushE = lwStall | PCSrcE.
- A simultaneous taken branch and load-use condition resolves as a branch: both flushes assert and there is no stall.

Counters:
- stall_cnt increments in each cycle where lwStall = 1.
- flush_cnt increments in each cycle where PCSrcE = 1.
- Both hold at all-ones (2^CNT_W − 1) and do not wrap.

## Timing
- Reset (rst = 0 at a clock edge) clears all shadow registers and both counters.
- Reset wins over any concurrent event, including a reset asserted mid-stall.
- Outputs after reset: Forward*E = 00, StallF = StallD = FlushD = 0, FlushE = 0 (with PCSrcE = 0), stall_cnt = flush_cnt = 0.
- Forward*E, Stall* and Flush* are combinational from the shadow registers plus same-cycle D/E inputs, with zero-cycle latency. There is no input-to-output path through the counters.
- Load-use sequence:
  - Stall lasts exactly one cycle; the bubble inserted into E clears LoadE next cycle.
  - D inputs are held by the datapath (StallD), so the dependent instruction enters E one cycle later.
  - On entering E it sees ForwardxE = 01, because the load is now in W.
- After a flush, the bubble carries RegWriteE = 0, so the flushed instruction produces no forwarding two and three cycles later.
- Counters update one edge after the event cycle.

## Structure
- Shared package core_pkg:
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - REG_ZERO = 5'd0.
- This is the encoding used by execute_mux_1 and its B-operand twin.
- A natural sub-module is hazard_fwd_sel:
  - Combinational comparator: (Rs, RdM, RegWriteM, RdW, RegWriteW) → 2-bit select.
  - Instantiated twice, once for A and once for B.
- Shadow registers and counters live in the top.

## Test plan
- Reset: hold rst = 0 for 2 cycles with random inputs → all outputs 0, counters 0.
- EX→EX forwarding: issue add x5 (RdD = 5, RegWriteD = 1), then sub with Rs1D = 5, Rs2D = 5 → in the sub's E cycle ForwardAE = ForwardBE = 10.
- MEM→EX forwarding and priority:
  - add x5; nop; use x5 → ForwardAE = 01.
  - add x5; add x5; use x5 → ForwardAE = 10 (M beats W).
  - Rs1 = 0 with RdM = 0 and RegWriteM = 1 → 00.
- Load-use: lw x7 in E (LoadE = 1), D has Rs2D = 7 →
  - StallF = StallD = FlushE = 1 for exactly one cycle.
  - Next cycle ForwardBE = 01.
  - stall_cnt = 1.
- Branch during load-use: PCSrcE = 1 in the same cycle as the lw x7 / Rs1D = 7 hazard →
  - FlushD = FlushE = 1, StallF = StallD = 0.
  - flush_cnt increments and stall_cnt is unchanged.
  - Flushed instruction never causes forwarding.
- Saturation: with CNT_W = 4, drive PCSrcE = 1 for 20 cycles → flush_cnt stops at 15. Then rst = 0 → 0.
